// File: rtl/vip_axi4_burst_addr_gen.sv
// Expands one AXI4 AW/AR request into a per-beat stream of address, strobe, index and last.
// Handles FIXED/INCR/WRAP arithmetic, narrow-transfer strobes and flags illegal or 4 KB-crossing requests.
module vip_axi4_burst_addr_gen #(
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 64,
  parameter int STRB_WIDTH_P = DATA_WIDTH_P / 8,
  parameter int ID_WIDTH_P   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ID_WIDTH_P-1:0]   req_id,
  input  logic [ADDR_WIDTH_P-1:0] req_addr,
  input  logic [7:0]              req_len,
  input  logic [2:0]              req_size,
  input  logic [1:0]              req_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ID_WIDTH_P-1:0]   beat_id,
  output logic [ADDR_WIDTH_P-1:0] beat_addr,
  output logic [STRB_WIDTH_P-1:0] beat_strb,
  output logic [7:0]              beat_index,
  output logic                    beat_last,
  output logic                    err_illegal,
  output logic                    err_4k
);

  typedef enum logic [1:0] {IDLE, CHECK, BURST} state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [ADDR_WIDTH_P-1:0] LANE_MASK = ADDR_WIDTH_P'(DATA_WIDTH_P / 8 - 1);
  localparam logic [ADDR_WIDTH_P-1:0] ONE       = ADDR_WIDTH_P'(1);

  state_e                  state_q, state_d;
  logic [ID_WIDTH_P-1:0]   id_q, id_d;
  logic [ADDR_WIDTH_P-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;

  logic                    beat_valid_q, beat_valid_d;
  logic [ADDR_WIDTH_P-1:0] beat_addr_q, beat_addr_d;
  logic [STRB_WIDTH_P-1:0] beat_strb_q, beat_strb_d;
  logic [7:0]              beat_index_q, beat_index_d;
  logic                    beat_last_q, beat_last_d;

  logic [ADDR_WIDTH_P-1:0] size_bytes, size_mask, aligned_start, total_bytes;
  logic [ADDR_WIDTH_P-1:0] wrap_lower, last_byte, cur_aligned, incr_next, next_addr;
  logic                    illegal, cross_4k;

  // Lanes lo..hi where lo is the byte offset and hi ends the size-aligned container.
  function automatic logic [STRB_WIDTH_P-1:0] lanes(input logic [ADDR_WIDTH_P-1:0] a,
                                                    input logic [ADDR_WIDTH_P-1:0] sb);
    logic [ADDR_WIDTH_P-1:0] lo, hi;
    logic [STRB_WIDTH_P-1:0] m;
    lo = a & LANE_MASK;
    hi = ((a & ~(sb - ONE)) & LANE_MASK) + sb - ONE;
    m  = '0;
    for (int unsigned i = 0; i < STRB_WIDTH_P; i++) begin
      m[i] = (ADDR_WIDTH_P'(i) >= lo) && (ADDR_WIDTH_P'(i) <= hi);
    end
    return m;
  endfunction

  always_comb begin
    size_bytes    = ONE << size_q;
    size_mask     = size_bytes - ONE;
    aligned_start = addr_q & ~size_mask;
    total_bytes   = size_bytes * (ADDR_WIDTH_P'(len_q) + ONE);
    wrap_lower    = addr_q & ~(total_bytes - ONE);
    last_byte     = aligned_start + total_bytes - ONE;
    cross_4k      = |((last_byte ^ addr_q) >> 12);
    illegal       = (burst_q == BURST_RSVD)
                 || (size_bytes > ADDR_WIDTH_P'(STRB_WIDTH_P))
                 || ((burst_q == BURST_WRAP) && !((len_q == 8'd1) || (len_q == 8'd3)
                                                  || (len_q == 8'd7) || (len_q == 8'd15)))
                 || ((burst_q == BURST_FIXED) && (len_q > 8'd15));
    cur_aligned   = beat_addr_q & ~size_mask;
    incr_next     = cur_aligned + size_bytes;
    unique case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (incr_next == wrap_lower + total_bytes) ? wrap_lower : incr_next;
      default:     next_addr = incr_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_valid_q <= 1'b0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_index_q <= '0;
      beat_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_valid_q <= beat_valid_d;
      beat_addr_q  <= beat_addr_d;
      beat_strb_q  <= beat_strb_d;
      beat_index_q <= beat_index_d;
      beat_last_q  <= beat_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = CHECK;
      CHECK:   state_d = illegal ? IDLE : BURST;
      BURST:   if (beat_ready && beat_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_valid_d = beat_valid_q;
    beat_addr_d  = beat_addr_q;
    beat_strb_d  = beat_strb_q;
    beat_index_d = beat_index_q;
    beat_last_d  = beat_last_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          id_d    = req_id;
          addr_d  = req_addr;
          len_d   = req_len;
          size_d  = req_size;
          burst_d = req_burst;
        end
      end
      CHECK: begin
        if (!illegal) begin
          beat_valid_d = 1'b1;
          beat_addr_d  = addr_q;
          beat_strb_d  = lanes(addr_q, size_bytes);
          beat_index_d = 8'd0;
          beat_last_d  = (len_q == 8'd0);
        end
      end
      BURST: begin
        if (beat_ready) begin
          if (beat_last_q) begin
            beat_valid_d = 1'b0;
          end else begin
            beat_addr_d  = next_addr;
            beat_strb_d  = lanes(next_addr, size_bytes);
            beat_index_d = beat_index_q + 8'd1;
            beat_last_d  = ((beat_index_q + 8'd1) == len_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    err_illegal = (state_q == CHECK) && illegal;
    err_4k      = (state_q == CHECK) && !illegal && (burst_q == BURST_INCR) && cross_4k;
  end

  assign beat_valid = beat_valid_q;
  assign beat_id    = id_q;
  assign beat_addr  = beat_addr_q;
  assign beat_strb  = beat_strb_q;
  assign beat_index = beat_index_q;
  assign beat_last  = beat_last_q;

endmodule

// File: tb/tb_vip_axi4_burst_addr_gen.sv
// Randomized bench for vip_axi4_burst_addr_gen: a transaction-level model predicts every beat
// and error pulse, and one negedge process compares the DUT against it each cycle.
module tb_vip_axi4_burst_addr_gen;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_id;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic [2:0]    req_size;
  logic [1:0]    req_burst;
  logic          beat_valid;
  logic          beat_ready;
  logic [IW-1:0] beat_id;
  logic [AW-1:0] beat_addr;
  logic [SW-1:0] beat_strb;
  logic [7:0]    beat_index;
  logic          beat_last;
  logic          err_illegal;
  logic          err_4k;

  vip_axi4_burst_addr_gen #(
    .ADDR_WIDTH_P(AW),
    .DATA_WIDTH_P(DW),
    .STRB_WIDTH_P(SW),
    .ID_WIDTH_P  (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_id     (req_id),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .req_burst  (req_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_strb  (beat_strb),
    .beat_index (beat_index),
    .beat_last  (beat_last),
    .err_illegal(err_illegal),
    .err_4k     (err_4k)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [7:0]    idx;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  bit m_busy, m_check, m_active, m_ill, m_4k;

  int unsigned rdy_mode = 0;
  int unsigned stall    = 0;

  function automatic logic [AW-1:0] m_addr(input int burst, input logic [AW-1:0] a,
                                           input int size, input int len, input int n);
    logic [AW-1:0] sb, al, wb, lower;
    sb = 32'd1 << size;
    al = a & ~(sb - 32'd1);
    if (n == 0 || burst == 0) return a;
    if (burst == 1) return al + sb * 32'(n);
    wb    = sb * 32'(len + 1);
    lower = a & ~(wb - 32'd1);
    return lower + ((al - lower + sb * 32'(n)) % wb);
  endfunction

  function automatic logic [SW-1:0] m_strb(input logic [AW-1:0] a, input int size);
    logic [SW-1:0] s;
    int unsigned   sb, lo, hi;
    sb = 1 << size;
    lo = int'(a % SW);
    hi = int'((a & ~(32'(sb) - 32'd1)) % SW) + sb - 1;
    for (int i = 0; i < SW; i++) s[i] = (i >= lo) && (i <= hi);
    return s;
  endfunction

  function automatic bit m_illegal(input int burst, input int size, input int len);
    return (burst == 3) || ((1 << size) > SW)
        || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
        || (burst == 0 && len > 15);
  endfunction

  function automatic bit m_cross(input logic [AW-1:0] a, input int size, input int len);
    logic [AW-1:0] sb, lastb;
    sb    = 32'd1 << size;
    lastb = (a & ~(sb - 32'd1)) + sb * 32'(len + 1) - 32'd1;
    return (lastb >> 12) != (a >> 12);
  endfunction

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Single compare process: checks DUT against the model, then advances the model one cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (req_ready !== 1'b1 || beat_valid !== 1'b0 || err_illegal !== 1'b0 || err_4k !== 1'b0
          || beat_addr !== '0 || beat_strb !== '0 || beat_index !== '0 || beat_last !== 1'b0
          || beat_id !== '0) begin
        errors++;
        $display("FAIL reset_values got rdy=%b v=%b ill=%b 4k=%b addr=%h strb=%h idx=%0d last=%b id=%h want rdy=1 rest 0",
                 req_ready, beat_valid, err_illegal, err_4k, beat_addr, beat_strb, beat_index,
                 beat_last, beat_id);
      end
      m_busy = 0; m_check = 0; m_active = 0; m_ill = 0; m_4k = 0;
      exp_q.delete();
    end else begin
      checks++;
      if (req_ready !== !m_busy) begin
        errors++;
        $display("FAIL req_ready got=%b want=%b", req_ready, !m_busy);
      end
      checks++;
      if (err_illegal !== (m_check && m_ill)) begin
        errors++;
        $display("FAIL err_illegal got=%b want=%b", err_illegal, m_check && m_ill);
      end
      checks++;
      if (err_4k !== (m_check && m_4k)) begin
        errors++;
        $display("FAIL err_4k got=%b want=%b", err_4k, m_check && m_4k);
      end
      checks++;
      if (beat_valid !== m_active) begin
        errors++;
        $display("FAIL beat_valid got=%b want=%b", beat_valid, m_active);
      end
      if (m_active && beat_valid === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if (beat_addr !== exp_q[0].addr || beat_strb !== exp_q[0].strb
            || beat_index !== exp_q[0].idx || beat_last !== exp_q[0].last
            || beat_id !== exp_q[0].id) begin
          errors++;
          $display("FAIL beat got addr=%h strb=%h idx=%0d last=%b id=%h want addr=%h strb=%h idx=%0d last=%b id=%h",
                   beat_addr, beat_strb, beat_index, beat_last, beat_id, exp_q[0].addr,
                   exp_q[0].strb, exp_q[0].idx, exp_q[0].last, exp_q[0].id);
        end
      end
      if (m_check) begin
        m_check = 0;
        if (m_ill) m_busy = 0;
        else       m_active = 1;
      end else if (m_active) begin
        if (beat_ready === 1'b1) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_active = 0;
            m_busy   = 0;
          end
        end
      end else if (!m_busy && req_valid === 1'b1) begin
        m_busy  = 1;
        m_check = 1;
        m_ill   = m_illegal(int'(req_burst), int'(req_size), int'(req_len));
        m_4k    = !m_ill && req_burst == 2'b01 && m_cross(req_addr, int'(req_size), int'(req_len));
        exp_q.delete();
        if (!m_ill) begin
          for (int n = 0; n <= int'(req_len); n++) begin
            beat_t b;
            b.addr = m_addr(int'(req_burst), req_addr, int'(req_size), int'(req_len), n);
            b.strb = m_strb(b.addr, int'(req_size));
            b.idx  = 8'(n);
            b.last = (n == int'(req_len));
            b.id   = req_id;
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: beat_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (beat_valid && beat_index == 8'd1 && stall < 3) begin
          beat_ready = 1'b0;
          stall++;
        end else begin
          beat_ready = 1'b1;
        end
      end
      default: beat_ready = 1'b1;
    endcase
  end

  task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    int unsigned n = 0;
    @(posedge clk);
    #1;
    req_id = id; req_addr = a; req_len = len; req_size = size; req_burst = burst;
    req_valid = 1'b1;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL req_handshake got=timeout want=req_ready within 3000 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_wait got=timeout want=req_ready within 3000 cycles");
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   n;
    int unsigned   r;
    logic [1:0]    bu;
    logic [2:0]    sz;
    logic [7:0]    ln;
    logic [AW-1:0] ad;
    int            wl[4] = '{1, 3, 7, 15};

    rst_n = 1'b0; req_valid = 1'b0; beat_ready = 1'b1;
    req_id = '0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    pin("model_incr_a1", m_addr(1, 32'h1002, 2, 3, 1), 32'h1004);
    pin("model_incr_a3", m_addr(1, 32'h1002, 2, 3, 3), 32'h100C);
    pin("model_incr_s0", 32'(m_strb(32'h1002, 2)), 32'h0C);
    pin("model_incr_s1", 32'(m_strb(32'h1004, 2)), 32'hF0);
    pin("model_incr_s2", 32'(m_strb(32'h1008, 2)), 32'h0F);
    pin("model_wrap_a3", m_addr(2, 32'h34, 2, 3, 3), 32'h30);
    pin("model_4k_a1", m_addr(1, 32'hFF8, 3, 1, 1), 32'h1000);
    pin("model_4k_flag", 32'(m_cross(32'hFF8, 3, 1)), 32'd1);
    pin("model_fixed_s", 32'(m_strb(32'h80, 3)), 32'hFF);
    pin("model_ill_wrap2", 32'(m_illegal(2, 2, 2)), 32'd1);
    pin("model_ill_fix16", 32'(m_illegal(0, 3, 16)), 32'd1);
    pin("model_ill_size4", 32'(m_illegal(1, 4, 0)), 32'd1);
    pin("model_ok_fix2", 32'(m_illegal(0, 3, 2)), 32'd0);

    send(4'd1, 32'h1002, 8'd3, 3'd2, 2'b01);
    send(4'd2, 32'h34, 8'd3, 3'd2, 2'b10);
    send(4'd3, 32'h80, 8'd2, 3'd3, 2'b00);
    send(4'd4, 32'h80, 8'd16, 3'd3, 2'b00);
    send(4'd5, 32'h100, 8'd0, 3'd0, 2'b11);
    send(4'd6, 32'h0, 8'd0, 3'd4, 2'b01);
    send(4'd7, 32'h40, 8'd2, 3'd2, 2'b10);
    send(4'd8, 32'hFF8, 8'd1, 3'd3, 2'b01);

    wait_idle();
    stall = 0; rdy_mode = 2;
    send(4'd9, 32'h1002, 8'd3, 3'd2, 2'b01);
    wait_idle();
    rdy_mode = 0;

    send(4'd10, 32'h1002, 8'd3, 3'd2, 2'b01);
    n = 0;
    @(negedge clk);
    while (!(beat_valid === 1'b1 && beat_index == 8'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #3 rst_n = 1'b0;
    #1;
    pin("async_reset_valid", 32'(beat_valid), 32'd0);
    pin("async_reset_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    send(4'd11, 32'h34, 8'd3, 3'd2, 2'b10);

    rdy_mode = 1;
    for (int t = 0; t < 80; t++) begin
      r  = $urandom_range(0, 9);
      bu = (r == 0) ? 2'b11 : (r <= 3) ? 2'b00 : (r <= 6) ? 2'b01 : 2'b10;
      sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      if (bu == 2'b10)
        ln = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 16)) : 8'(wl[$urandom_range(0, 3)]);
      else if (bu == 2'b00)
        ln = 8'($urandom_range(0, 18));
      else
        ln = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      ad = $urandom;
      if ($urandom_range(0, 2) == 0) ad = {ad[31:12], 12'hFC0 | 12'(ad[5:0])};
      send(4'($urandom_range(0, 15)), ad, ln, sz, bu);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
